// File: rtl/instruction_register_multi_pkg.sv
// Shared definitions for the multi-byte instruction register: FSM states,
// a constant clog2, and the operand-count/index width derivation.
package instruction_register_multi_pkg;

    typedef enum logic [0:0] {
        ST_OPC = 1'b0,
        ST_OPR = 1'b1
    } ir_state_t;

    function automatic int ir_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width that holds any count 0..max_ops, also used for the byte index.
    function automatic int ir_len_w(input int max_ops);
        return ir_clog2(max_ops + 1);
    endfunction

endpackage

// File: rtl/instruction_register_multi_operand_bank.sv
// Operand byte registers with per-byte load enables; the synchronous clear
// takes priority so a new opcode wipes any stale operand bytes.
module ir_operand_bank #(
    parameter int DATA_W       = 8,
    parameter int MAX_OPERANDS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clr,
    input  logic [MAX_OPERANDS-1:0]          i_ld_en,
    input  logic [DATA_W-1:0]                i_dat,
    output logic [MAX_OPERANDS*DATA_W-1:0]   o_dat
);
    logic [DATA_W-1:0] r_byte [MAX_OPERANDS];

    for (genvar g = 0; g < MAX_OPERANDS; g++) begin : g_byte
        always_ff @(posedge clk or posedge rst) begin
            if (rst)             r_byte[g] <= '0;
            else if (i_clr)      r_byte[g] <= '0;
            else if (i_ld_en[g]) r_byte[g] <= i_dat;
        end
        assign o_dat[g*DATA_W +: DATA_W] = r_byte[g];
    end
endmodule

// File: rtl/tri_state_buffer.sv
// Single-bit tri-state driver cell; output floats whenever the enable is low.
module tri_state_buffer (
    input  logic i_a,
    input  logic i_en,
    output wire  o_y
);
    assign o_y = i_en ? i_a : 1'bz;
endmodule

// File: rtl/instruction_register_multi.sv
// Variable-length instruction register: opcode byte plus up to MAX_OPERANDS operand bytes.
// Optional sticky protocol-error flag enabled by defining IR_PROTOCOL_CHECK_EN.
module instruction_register_multi
    import instruction_register_multi_pkg::*;
#(
    parameter  int DATA_W       = 8,
    parameter  int OPCODE_W     = 4,
    parameter  int MAX_OPERANDS = 2,
    localparam int LEN_W        = ir_len_w(MAX_OPERANDS)
) (
    input  logic                            clk,
    input  logic                            rst,
    inout  wire  [DATA_W-1:0]               bus,
    input  logic                            II,
    input  logic                            IO,
    input  logic                            clr,
    input  logic [LEN_W-1:0]                op_len,
    output logic [OPCODE_W-1:0]             opcode,
    output logic [DATA_W-OPCODE_W-1:0]      imm_inline,
    output logic [MAX_OPERANDS*DATA_W-1:0]  operand,
    output logic [LEN_W-1:0]                pending,
    output logic                            complete,
    output logic                            err
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_OPERANDS);

    ir_state_t                  r_state, w_state_nxt;
    logic [OPCODE_W-1:0]        r_opcode;
    logic [DATA_W-OPCODE_W-1:0] r_imm;
    logic [LEN_W-1:0]           r_len, r_pending;
    logic                       r_complete;

    logic                       w_opc_ld, w_opr_ld, w_last;
    logic [LEN_W-1:0]           w_len_clamped, w_idx;
    logic [MAX_OPERANDS-1:0]    w_byte_en;
    logic [DATA_W-1:0]          w_drive_val, w_bus_in;

    assign w_len_clamped = (op_len > MAX_LEN) ? MAX_LEN : op_len;
    assign w_drive_val   = (r_len != '0) ? operand[DATA_W-1:0]
                                         : {{OPCODE_W{1'b0}}, r_imm};
    // With II and IO together the bus carries our own drive, so load that.
    assign w_bus_in      = IO ? w_drive_val : bus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_OPC;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr)                                 w_state_nxt = ST_OPC;
        else if (w_opc_ld && w_len_clamped != 0) w_state_nxt = ST_OPR;
        else if (w_last)                         w_state_nxt = ST_OPC;
    end

    always_comb begin
        w_opc_ld  = II && !clr && (r_state == ST_OPC);
        w_opr_ld  = II && !clr && (r_state == ST_OPR);
        w_last    = w_opr_ld && (r_pending == LEN_W'(1));
        w_idx     = r_len - r_pending;
        w_byte_en = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            w_byte_en[i] = w_opr_ld && (w_idx == LEN_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opcode   <= '0;
            r_imm      <= '0;
            r_len      <= '0;
            r_pending  <= '0;
            r_complete <= 1'b0;
        end else if (clr) begin
            r_pending  <= '0;
            r_complete <= 1'b0;
        end else if (w_opc_ld) begin
            r_opcode   <= w_bus_in[DATA_W-1 -: OPCODE_W];
            r_imm      <= w_bus_in[DATA_W-OPCODE_W-1:0];
            r_len      <= w_len_clamped;
            r_pending  <= w_len_clamped;
            r_complete <= (w_len_clamped == '0);
        end else if (w_opr_ld) begin
            r_pending  <= r_pending - LEN_W'(1);
            r_complete <= w_last;
        end
    end

    ir_operand_bank #(
        .DATA_W       (DATA_W),
        .MAX_OPERANDS (MAX_OPERANDS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_opc_ld),
        .i_ld_en (w_byte_en),
        .i_dat   (w_bus_in),
        .o_dat   (operand)
    );

    for (genvar g = 0; g < DATA_W; g++) begin : g_tsb
        tri_state_buffer u_tsb (
            .i_a  (w_drive_val[g]),
            .i_en (IO && !rst),
            .o_y  (bus[g])
        );
    end

`ifdef IR_PROTOCOL_CHECK_EN
    logic r_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_err <= 1'b0;
        else if ((II && IO) || (w_opc_ld && op_len > MAX_LEN)) r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign opcode     = r_opcode;
    assign imm_inline = r_imm;
    assign pending    = r_pending;
    assign complete   = r_complete;
endmodule
